// File: rtl/fifo_to_axis_pkg.sv
// fifo_to_axis_pkg
//   Shared definitions for readers of the packed replay FIFO.
//   - state_t         : FSM encoding (HDR, PKT, DROP)
//   - LEN_LSB/LEN_W   : packet length field inside TUSER (bits [15:0])
//   - PACKED_BYTE_W   : bits per packed byte (strobe + data byte)
//   - CNT_W           : beat down-counter width
//   - log2()          : ceiling log2, same definition as the packer side
package fifo_to_axis_pkg;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int LEN_LSB       = 0;
  localparam int LEN_W         = 16;
  localparam int PACKED_BYTE_W = 9;
  localparam int CNT_W         = 12;

  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_to_axis_if.sv
// fifo_to_axis_if
//   Bundled per-queue AXI4-Stream outputs. Every signal is NQ slices wide,
//   queue q occupying slice q.
//   master : drives tdata/tstrb/tuser/tvalid/tlast, receives tready
//   slave  : the reverse
interface fifo_to_axis_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128,
  parameter int NQ     = 4
);
  logic [NQ*DATA_W-1:0]     tdata;
  logic [NQ*(DATA_W/8)-1:0] tstrb;
  logic [NQ*USER_W-1:0]     tuser;
  logic [NQ-1:0]            tvalid;
  logic [NQ-1:0]            tready;
  logic [NQ-1:0]            tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/fifo_to_axis_word_unpack.sv
// fifo_word_unpack
//   Combinational split of one packed FIFO word. Byte i sits at bits
//   [9i+8:9i] as {strb, data}.
//   packed_word : packed FIFO word
//   data        : recovered data bytes
//   strb        : recovered byte strobes
module fifo_word_unpack
  import fifo_to_axis_pkg::*;
#(
  parameter int DATA_W = 256
) (
  input  logic [DATA_W/8*PACKED_BYTE_W-1:0] packed_word,
  output logic [DATA_W-1:0]                 data,
  output logic [DATA_W/8-1:0]               strb
);

  for (genvar i = 0; i < DATA_W/8; i++) begin : g_byte
    assign data[8*i +: 8] = packed_word[PACKED_BYTE_W*i +: 8];
    assign strb[i]        = packed_word[PACKED_BYTE_W*i + 8];
  end

endmodule

// File: rtl/fifo_to_axis.sv
// fifo_to_axis
//   Pops packed words from a FWFT FIFO, rebuilds AXI4-Stream packets using
//   the length carried in the header word, and steers each packet to one of
//   C_NUM_QUEUES output streams.
//   axi_aclk, axi_aresetn : clock, async active-low reset
//   fifo_dout/_qid/_empty : FIFO head word, its queue id, head invalid
//   fifo_rd_en            : pop the head word
//   m_axis                : per-queue AXI4-Stream master (fifo_to_axis_if)
//   sw_rst                : synchronous soft reset
//   err_count             : last-beat length/strobe mismatches
//   Optional macro FIFO_TO_AXIS_LEN_CHECK_EN enables the length checker;
//   without it err_count is tied to 0.
//
//   state | meaning
//   HDR   | waiting for / popping a header word
//   PKT   | popping data beats into the output register
//   DROP  | discarding data beats of a packet with an invalid qid
module fifo_to_axis
  import fifo_to_axis_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_QUEUES         = 4,
  parameter int C_PACKED_WIDTH       = C_M_AXIS_DATA_WIDTH/8*PACKED_BYTE_W,
  localparam int QW = (log2(C_NUM_QUEUES) < 1) ? 1 : log2(C_NUM_QUEUES)
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic [C_PACKED_WIDTH-1:0] fifo_dout,
  input  logic [QW-1:0]             fifo_dout_qid,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  fifo_to_axis_if.master            m_axis,
  input  logic                      sw_rst,
  output logic [15:0]               err_count
);

  localparam int DW    = C_M_AXIS_DATA_WIDTH;
  localparam int UW    = C_M_AXIS_TUSER_WIDTH;
  localparam int BYTES = DW/8;
  localparam int BW    = log2(BYTES);

  logic [DW-1:0]    word_data;
  logic [BYTES-1:0] word_strb;

  fifo_word_unpack #(.DATA_W(DW)) u_unpack (
    .packed_word (fifo_dout),
    .data        (word_data),
    .strb        (word_strb)
  );

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [QW-1:0]    pkt_qid;
  logic [UW-1:0]    pkt_user;

  // Output register carries its own qid and tuser so it can drain the last
  // beat of one packet while the next header is already latched.
  logic             out_valid;
  logic             out_last;
  logic [QW-1:0]    out_qid;
  logic [DW-1:0]    out_data;
  logic [BYTES-1:0] out_strb;
  logic [UW-1:0]    out_user;

  logic [LEN_W-1:0] hdr_len;
  logic [CNT_W-1:0] hdr_beats;
  logic             hdr_bad_qid;
  logic             out_hs;
  logic             pop;

  assign hdr_len     = word_data[LEN_LSB +: LEN_W];
  assign hdr_beats   = CNT_W'(({1'b0, hdr_len} + (LEN_W+1)'(BYTES-1)) >> BW);
  assign hdr_bad_qid = (int'(fifo_dout_qid) >= C_NUM_QUEUES);
  assign out_hs      = out_valid && m_axis.tready[out_qid];

  // The FIFO is reset by the same sw_rst, so no pop is issued while it is high.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty && !sw_rst && axi_aresetn) begin
      case (state)
        ST_HDR:  pop = 1'b1;
        ST_PKT:  pop = !out_valid || out_hs;
        ST_DROP: pop = (beat_cnt != '0);
        default: pop = 1'b0;
      endcase
    end
  end

  assign fifo_rd_en = pop;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state     <= ST_HDR;
      beat_cnt  <= '0;
      pkt_qid   <= '0;
      pkt_user  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_qid   <= '0;
      out_data  <= '0;
      out_strb  <= '0;
      out_user  <= '0;
    end else if (sw_rst) begin
      state     <= ST_HDR;
      beat_cnt  <= '0;
      pkt_qid   <= '0;
      pkt_user  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_qid   <= '0;
      out_data  <= '0;
      out_strb  <= '0;
      out_user  <= '0;
    end else begin
      if (out_hs) out_valid <= 1'b0;
      case (state)
        ST_HDR: begin
          if (pop) begin
            pkt_user <= word_data[UW-1:0];
            pkt_qid  <= fifo_dout_qid;
            beat_cnt <= hdr_beats;
            if (hdr_len == '0)    state <= ST_HDR;
            else if (hdr_bad_qid) state <= ST_DROP;
            else                  state <= ST_PKT;
          end
        end
        ST_PKT: begin
          if (pop) begin
            out_valid <= 1'b1;
            out_data  <= word_data;
            out_strb  <= word_strb;
            out_user  <= pkt_user;
            out_qid   <= pkt_qid;
            out_last  <= (beat_cnt == CNT_W'(1));
            beat_cnt  <= beat_cnt - CNT_W'(1);
            if (beat_cnt == CNT_W'(1)) state <= ST_HDR;
          end
        end
        ST_DROP: begin
          if (beat_cnt == '0) begin
            state <= ST_HDR;
          end else if (pop) begin
            beat_cnt <= beat_cnt - CNT_W'(1);
            if (beat_cnt == CNT_W'(1)) state <= ST_HDR;
          end
        end
        default: state <= ST_HDR;
      endcase
    end
  end

  // Only the selected queue sees the register; every other slice reads 0.
  logic [C_NUM_QUEUES*DW-1:0]    tdata_vec;
  logic [C_NUM_QUEUES*BYTES-1:0] tstrb_vec;
  logic [C_NUM_QUEUES*UW-1:0]    tuser_vec;
  logic [C_NUM_QUEUES-1:0]       tvalid_vec;
  logic [C_NUM_QUEUES-1:0]       tlast_vec;

  always_comb begin
    tdata_vec  = '0;
    tstrb_vec  = '0;
    tuser_vec  = '0;
    tvalid_vec = '0;
    tlast_vec  = '0;
    for (int q = 0; q < C_NUM_QUEUES; q++) begin
      if (out_valid && (int'(out_qid) == q)) begin
        tdata_vec[q*DW +: DW]       = out_data;
        tstrb_vec[q*BYTES +: BYTES] = out_strb;
        tuser_vec[q*UW +: UW]       = out_user;
        tvalid_vec[q]               = 1'b1;
        tlast_vec[q]                = out_last;
      end
    end
  end

  assign m_axis.tdata  = tdata_vec;
  assign m_axis.tstrb  = tstrb_vec;
  assign m_axis.tuser  = tuser_vec;
  assign m_axis.tvalid = tvalid_vec;
  assign m_axis.tlast  = tlast_vec;

`ifdef FIFO_TO_AXIS_LEN_CHECK_EN
  // Bytes expected on the last beat: len mod BYTES, or a full beat when the
  // length is an exact multiple of BYTES.
  logic [BW-1:0] pkt_len_lsb;
  logic [BW:0]   strb_ones;
  logic [BW:0]   last_bytes;
  logic [15:0]   err_cnt_r;

  always_comb begin
    strb_ones = '0;
    for (int i = 0; i < BYTES; i++) strb_ones = strb_ones + (BW+1)'(word_strb[i]);
  end

  assign last_bytes = (pkt_len_lsb == '0) ? (BW+1)'(BYTES) : {1'b0, pkt_len_lsb};

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pkt_len_lsb <= '0;
      err_cnt_r   <= '0;
    end else if (sw_rst) begin
      pkt_len_lsb <= '0;
      err_cnt_r   <= '0;
    end else begin
      if (state == ST_HDR && pop) pkt_len_lsb <= hdr_len[BW-1:0];
      if (state == ST_PKT && pop && beat_cnt == CNT_W'(1) &&
          strb_ones != last_bytes && err_cnt_r != 16'hFFFF)
        err_cnt_r <= err_cnt_r + 16'd1;
    end
  end

  assign err_count = err_cnt_r;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_fifo_to_axis.sv
module tb_fifo_to_axis;
  localparam int DW    = 256;
  localparam int UW    = 128;
  localparam int NQ    = 4;
  localparam int QW    = 2;
  localparam int BYTES = 32;
  localparam int PW    = 288;

`ifdef FIFO_TO_AXIS_LEN_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_rst = 1'b0;
  logic [PW-1:0] fifo_dout;
  logic [QW-1:0] fifo_dout_qid;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [15:0]   err_count;
  logic [NQ-1:0] tb_ready;

  always #5 clk = ~clk;

  fifo_to_axis_if #(.DATA_W(DW), .USER_W(UW), .NQ(NQ)) axis_if ();
  assign axis_if.tready = tb_ready;

  fifo_to_axis dut (
    .axi_aclk      (clk),
    .axi_aresetn   (rst_n),
    .fifo_dout     (fifo_dout),
    .fifo_dout_qid (fifo_dout_qid),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis        (axis_if),
    .sw_rst        (sw_rst),
    .err_count     (err_count)
  );

  typedef struct {
    logic [QW-1:0] qid;
    logic [PW-1:0] word;
  } fword_t;

  typedef struct {
    int               qid;
    logic [DW-1:0]    data;
    logic [BYTES-1:0] strb;
    logic [UW-1:0]    user;
    logic             last;
  } beat_t;

  fword_t fifo_q[$];
  beat_t  sb[$];
  beat_t  mon_e;
  int     n_checks = 0;
  int     n_pass = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] pack(input logic [DW-1:0] d, input logic [BYTES-1:0] s);
    logic [PW-1:0] w;
    for (int i = 0; i < BYTES; i++) begin
      w[9*i +: 8] = d[8*i +: 8];
      w[9*i + 8]  = s[i];
    end
    return w;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [7:0] seed, input int b);
    logic [DW-1:0] d;
    for (int i = 0; i < BYTES; i++) d[8*i +: 8] = seed + 8'(b*BYTES + i);
    return d;
  endfunction

  task automatic fifo_refresh();
    if (fifo_q.size() == 0) begin
      fifo_empty    = 1'b1;
      fifo_dout     = '0;
      fifo_dout_qid = '0;
    end else begin
      fifo_empty    = 1'b0;
      fifo_dout     = fifo_q[0].word;
      fifo_dout_qid = fifo_q[0].qid;
    end
  endtask

  // FWFT FIFO model; rd_en is read before the DUT's registers update.
  always @(posedge clk) begin
    if (sw_rst) begin
      fifo_q.delete();
    end else if (fifo_rd_en) begin
      n_checks++;
      if (!fifo_empty) begin
        n_pass++;
        void'(fifo_q.pop_front());
      end else begin
        $display("FAIL rd_en_while_empty: rd_en 1 with fifo_empty 1");
      end
    end
    #1 fifo_refresh();
  end

  // Scoreboard monitor: every handshake pops one expected beat.
  always @(negedge clk) begin
    if (rst_n && axis_if.tvalid != '0) begin
      check("tvalid_onehot", 256'($onehot(axis_if.tvalid)), 256'(1));
      for (int q = 0; q < NQ; q++) begin
        if (axis_if.tvalid[q] && axis_if.tready[q]) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: beat on q%0d, expected none", q);
          end else begin
            mon_e = sb.pop_front();
            check($sformatf("beat_qid"), 256'(q), 256'(mon_e.qid));
            check($sformatf("q%0d_tdata", q), axis_if.tdata[q*DW +: DW], mon_e.data);
            check($sformatf("q%0d_tstrb", q), 256'(axis_if.tstrb[q*BYTES +: BYTES]), 256'(mon_e.strb));
            check($sformatf("q%0d_tuser", q), 256'(axis_if.tuser[q*UW +: UW]), 256'(mon_e.user));
            check($sformatf("q%0d_tlast", q), 256'(axis_if.tlast[q]), 256'(mon_e.last));
          end
        end
      end
    end
  end

  task automatic send_pkt(input int qid, input int len, input logic [7:0] seed,
                          input bit ovr, input logic [BYTES-1:0] ovr_strb);
    logic [UW-1:0]    user;
    logic [BYTES-1:0] s;
    fword_t           w;
    beat_t            e;
    int               nb;
    int               rem;
    user   = {{14{seed}}, 16'(len)};
    w.qid  = QW'(qid);
    w.word = pack({128'h0, user}, '1);
    fifo_q.push_back(w);
    nb = (len + BYTES - 1) / BYTES;
    for (int b = 0; b < nb; b++) begin
      rem = len - b*BYTES;
      s = '0;
      for (int i = 0; i < BYTES; i++) if (i < rem) s[i] = 1'b1;
      if (ovr && b == nb-1) s = ovr_strb;
      w.word = pack(exp_data(seed, b), s);
      fifo_q.push_back(w);
      e.qid  = qid;
      e.data = exp_data(seed, b);
      e.strb = s;
      e.user = user;
      e.last = (b == nb-1);
      sb.push_back(e);
    end
    fifo_refresh();
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || fifo_q.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k < 300) n_pass++;
    else $display("FAIL %s_timeout: %0d beats outstanding, required 0", name, sb.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int cnt;
    int k;
    tb_ready = '1;
    fifo_refresh();
    repeat (3) @(negedge clk);
    check("rst_tvalid", 256'(axis_if.tvalid), 256'(0));
    check("rst_tlast", 256'(axis_if.tlast), 256'(0));
    check("rst_tdata_q0", axis_if.tdata[255:0], 256'(0));
    check("rst_rd_en", 256'(fifo_rd_en), 256'(0));
    check("rst_err_count", 256'(err_count), 256'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 64 bytes to qid 2: latency and two-beat throughput
    send_pkt(2, 64, 8'h10, 1'b0, '0);
    first = -1;
    cnt = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (axis_if.tvalid[2]) begin
        cnt++;
        if (first < 0) first = j;
      end
    end
    check("t1_first_valid_cycle", 256'(first), 256'(1));
    check("t1_valid_cycles", 256'(cnt), 256'(2));
    wait_idle("t1");

    // 65 bytes to qid 0: three beats, one byte on the last
    @(negedge clk);
    send_pkt(0, 65, 8'h40, 1'b0, '0);
    wait_idle("t2");
    check("t2_err_count", 256'(err_count), 256'(0));

    // back-to-back qid 1 / qid 3 with qid 3 stalled
    @(negedge clk);
    tb_ready = 4'b0111;
    send_pkt(1, 32, 8'h70, 1'b0, '0);
    send_pkt(3, 32, 8'h90, 1'b0, '0);
    k = 0;
    while (!axis_if.tvalid[3] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t3_q3_valid_seen", 256'(k < 50), 256'(1));
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("t3_stall_tvalid", 256'(axis_if.tvalid[3]), 256'(1));
      check("t3_stall_tdata", axis_if.tdata[3*DW +: DW], exp_data(8'h90, 0));
      check("t3_stall_rd_en", 256'(fifo_rd_en), 256'(0));
    end
    tb_ready = '1;
    wait_idle("t3");

    // zero-length header then a normal packet
    @(negedge clk);
    send_pkt(1, 0, 8'hA0, 1'b0, '0);
    send_pkt(1, 32, 8'hB0, 1'b0, '0);
    wait_idle("t4");

    // 96 bytes whose last beat claims only 16 bytes
    @(negedge clk);
    send_pkt(2, 96, 8'hC0, 1'b1, 32'h0000FFFF);
    wait_idle("t5");
    check("t5_err_count", 256'(err_count), 256'(EXP_ERR));

    // soft reset after beat 1 of a 128-byte packet
    @(negedge clk);
    send_pkt(2, 128, 8'hD0, 1'b0, '0);
    k = 0;
    while (!axis_if.tvalid[2] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_beat1_seen", 256'(k < 50), 256'(1));
    @(posedge clk);
    #1;
    tb_ready = '0;
    sw_rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_tvalid_after_sw_rst", 256'(axis_if.tvalid), 256'(0));
    check("t6_err_after_sw_rst", 256'(err_count), 256'(0));
    sw_rst = 1'b0;
    sb.delete();
    tb_ready = '1;
    @(negedge clk);
    send_pkt(0, 32, 8'hE0, 1'b0, '0);
    wait_idle("t6");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
